// File: rtl/ad7763_cfg_sequencer.sv
// AD7763 register-write sequencer: queues 32-bit {addr,data} words and shifts each one
// out on SDI/FSIN, synchronised to the end of a DRDY frame, with a DRDY timeout guard.
module ad7763_cfg_sequencer #(
   parameter int FIFO_DEPTH   = 4,
   parameter int GAP_CYCLES   = 8,
   parameter int DRDY_TIMEOUT = 1024
) (
   input  logic        aclk,
   input  logic        rst,
   input  logic [31:0] s_cmd_tdata,
   input  logic        s_cmd_tvalid,
   output logic        s_cmd_tready,
   input  logic        adc_dreadyn,
   output logic        adc_fsin,
   output logic        adc_sdi,
   output logic        busy,
   output logic [15:0] wr_count,
   output logic        timeout,
   input  logic        timeout_clr
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int TW = $clog2(DRDY_TIMEOUT + 1);
   localparam int GW = $clog2(GAP_CYCLES + 1);
   localparam logic [TW-1:0] TO_LAST  = TW'(DRDY_TIMEOUT - 1);
   localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
   localparam logic [AW:0]   PTR_ONE  = (AW+1)'(1);

   typedef enum logic [1:0] {IDLE, WAIT_DRDY, SHIFT, GAP} state_t;

   state_t        state_q, state_d;
   logic [31:0]   mem_q [FIFO_DEPTH];
   logic [AW:0]   wr_ptr_q, rd_ptr_q;
   logic          ready_en_q;
   logic          fifo_empty, fifo_full, push, pop;
   logic [31:0]   fifo_head;
   logic          drdy_q, drdy_prev_q, frame_end;
   logic [31:0]   shreg_q, shreg_d;
   logic [5:0]    bit_cnt_q, bit_cnt_d;
   logic [TW-1:0] to_cnt_q, to_cnt_d;
   logic [GW-1:0] gap_cnt_q, gap_cnt_d;
   logic          fsin_q, fsin_d, sdi_q, sdi_d;
   logic [15:0]   wr_count_q, wr_count_d;
   logic          timeout_q, set_timeout;

   // Extra pointer MSB distinguishes full from empty when the index bits match.
   assign fifo_empty   = (wr_ptr_q == rd_ptr_q);
   assign fifo_full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign s_cmd_tready = ready_en_q & ~fifo_full & ~rst;
   assign push         = s_cmd_tvalid & s_cmd_tready;
   assign fifo_head    = mem_q[rd_ptr_q[AW-1:0]];
   assign frame_end    = drdy_q & ~drdy_prev_q;

   always_comb begin
      state_d     = state_q;
      shreg_d     = shreg_q;
      bit_cnt_d   = bit_cnt_q;
      to_cnt_d    = to_cnt_q;
      gap_cnt_d   = gap_cnt_q;
      wr_count_d  = wr_count_q;
      fsin_d      = 1'b1;
      sdi_d       = 1'b0;
      pop         = 1'b0;
      set_timeout = 1'b0;
      case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               state_d  = WAIT_DRDY;
               to_cnt_d = '0;
            end
         end
         WAIT_DRDY: begin
            if (frame_end) begin
               pop       = 1'b1;
               fsin_d    = 1'b0;
               sdi_d     = fifo_head[31];
               shreg_d   = {fifo_head[30:0], 1'b0};
               bit_cnt_d = 6'd1;
               state_d   = SHIFT;
            end else if (to_cnt_q == TO_LAST) begin
               pop         = 1'b1;
               set_timeout = 1'b1;
               state_d     = IDLE;
            end else begin
               to_cnt_d = to_cnt_q + TW'(1);
            end
         end
         SHIFT: begin
            if (bit_cnt_q == 6'd32) begin
               wr_count_d = wr_count_q + 16'd1;
               gap_cnt_d  = '0;
               state_d    = GAP;
            end else begin
               sdi_d     = shreg_q[31];
               shreg_d   = {shreg_q[30:0], 1'b0};
               bit_cnt_d = bit_cnt_q + 6'd1;
            end
         end
         GAP: begin
            if (gap_cnt_q == GAP_LAST) state_d = IDLE;
            else                       gap_cnt_d = gap_cnt_q + GW'(1);
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge aclk) begin
      if (rst) begin
         state_q     <= IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         ready_en_q  <= 1'b0;
         drdy_q      <= 1'b1;
         drdy_prev_q <= 1'b1;
         shreg_q     <= '0;
         bit_cnt_q   <= '0;
         to_cnt_q    <= '0;
         gap_cnt_q   <= '0;
         fsin_q      <= 1'b1;
         sdi_q       <= 1'b0;
         wr_count_q  <= '0;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         ready_en_q  <= 1'b1;
         drdy_q      <= adc_dreadyn;
         drdy_prev_q <= drdy_q;
         shreg_q     <= shreg_d;
         bit_cnt_q   <= bit_cnt_d;
         to_cnt_q    <= to_cnt_d;
         gap_cnt_q   <= gap_cnt_d;
         fsin_q      <= fsin_d;
         sdi_q       <= sdi_d;
         wr_count_q  <= wr_count_d;
         if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
         if (set_timeout)      timeout_q <= 1'b1;
         else if (timeout_clr) timeout_q <= 1'b0;
      end
   end

   // Storage has no reset; emptiness is defined purely by the pointers.
   always_ff @(posedge aclk) begin
      if (push) mem_q[wr_ptr_q[AW-1:0]] <= s_cmd_tdata;
   end

   assign adc_fsin = fsin_q;
   assign adc_sdi  = sdi_q;
   assign busy     = !fifo_empty || (state_q != IDLE);
   assign wr_count = wr_count_q;
   assign timeout  = timeout_q;
endmodule

// File: tb/tb_ad7763_cfg_sequencer.sv
// Bench for ad7763_cfg_sequencer: accepted words go into a scoreboard queue; a negedge
// monitor reassembles SDI frames and compares them, plus directed timing scenarios.
module tb_ad7763_cfg_sequencer;
   localparam int FIFO_DEPTH   = 4;
   localparam int GAP_CYCLES   = 8;
   localparam int DRDY_TIMEOUT = 1024;

   logic        aclk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] s_cmd_tdata = '0;
   logic        s_cmd_tvalid = 1'b0;
   logic        s_cmd_tready;
   logic        adc_dreadyn = 1'b1;
   logic        adc_fsin, adc_sdi, busy, timeout;
   logic [15:0] wr_count;
   logic        timeout_clr = 1'b0;

   int          n_checks = 0;
   int          n_pass = 0;
   logic [31:0] exp_q[$];
   logic [15:0] exp_wr = '0;
   logic        rdy_en_m = 1'b0;
   int          frames = 0;
   logic        mon_active = 1'b0, mon_check_wr = 1'b0, prev_timeout = 1'b0;
   logic [31:0] cap = '0, cur_exp = '0;
   int          mon_bits = 0;
   logic        push_done = 1'b0;

   always #5 aclk = ~aclk;

   ad7763_cfg_sequencer #(
      .FIFO_DEPTH(FIFO_DEPTH), .GAP_CYCLES(GAP_CYCLES), .DRDY_TIMEOUT(DRDY_TIMEOUT)
   ) dut (
      .aclk(aclk), .rst(rst), .s_cmd_tdata(s_cmd_tdata), .s_cmd_tvalid(s_cmd_tvalid),
      .s_cmd_tready(s_cmd_tready), .adc_dreadyn(adc_dreadyn), .adc_fsin(adc_fsin),
      .adc_sdi(adc_sdi), .busy(busy), .wr_count(wr_count), .timeout(timeout),
      .timeout_clr(timeout_clr)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, req, $time);
   endtask

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   // Accepted words enter the scoreboard; readiness is re-enabled the edge after reset.
   always @(posedge aclk) begin
      if (rst) rdy_en_m <= 1'b0;
      else begin
         rdy_en_m <= 1'b1;
         if (s_cmd_tvalid && s_cmd_tready) exp_q.push_back(s_cmd_tdata);
      end
   end

   always @(negedge aclk) begin
      if (rst) begin
         exp_q.delete();
         exp_wr       = '0;
         mon_active   = 1'b0;
         mon_check_wr = 1'b0;
         prev_timeout = 1'b0;
         check("ready_in_reset", 32'(s_cmd_tready), 32'd0);
      end else begin
         if (timeout === 1'b1 && !prev_timeout) begin
            check("timeout_word_pending", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) void'(exp_q.pop_front());
         end
         prev_timeout = (timeout === 1'b1);
         if (mon_active) begin
            check("fsin_high_in_frame", 32'(adc_fsin), 32'd1);
            cap = {cap[30:0], adc_sdi};
            mon_bits++;
            if (mon_bits == 32) begin
               check("frame_word", cap, cur_exp);
               $display("frame %0d: sent 0x%08h expected 0x%08h", frames, cap, cur_exp);
               exp_wr++;
               mon_active   = 1'b0;
               mon_check_wr = 1'b1;
            end
         end else if (mon_check_wr) begin
            check("wr_count_after_frame", 32'(wr_count), 32'(exp_wr));
            mon_check_wr = 1'b0;
         end else if (adc_fsin === 1'b0) begin
            frames++;
            check("frame_word_pending", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
               cur_exp    = exp_q.pop_front();
               cap        = {31'd0, adc_sdi};
               mon_bits   = 1;
               mon_active = 1'b1;
            end
         end
         check("ready_vs_model", 32'(s_cmd_tready),
               32'(rdy_en_m && (exp_q.size() < FIFO_DEPTH)));
      end
   end

   task automatic do_reset();
      rst = 1'b1; s_cmd_tvalid = 1'b0; adc_dreadyn = 1'b1; timeout_clr = 1'b0;
      repeat (3) tick();
      @(negedge aclk);
      check("rst_fsin", 32'(adc_fsin), 32'd1);
      check("rst_sdi", 32'(adc_sdi), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_wr_count", 32'(wr_count), 32'd0);
      check("rst_timeout", 32'(timeout), 32'd0);
      @(posedge aclk); #1; rst = 1'b0;
      @(negedge aclk);
      check("ready_low_until_edge", 32'(s_cmd_tready), 32'd0);
      @(negedge aclk);
      check("ready_after_rst", 32'(s_cmd_tready), 32'd1);
      tick();
   endtask

   task automatic push_word(input logic [31:0] w);
      int k;
      s_cmd_tdata = w; s_cmd_tvalid = 1'b1;
      k = 0;
      do begin @(negedge aclk); k++; end while (s_cmd_tready !== 1'b1 && k < 2000);
      check("push_accept", 32'(s_cmd_tready), 32'd1);
      @(posedge aclk); #1;
      s_cmd_tvalid = 1'b0;
      $display("push 0x%08h after %0d cycles", w, k);
   endtask

   task automatic drdy_pulse(input int low_cycles);
      adc_dreadyn = 1'b0;
      repeat (low_cycles) tick();
      adc_dreadyn = 1'b1;
   endtask

   task automatic wait_idle(input int max_cycles);
      int k;
      k = 0;
      do begin @(negedge aclk); k++; end while (busy !== 1'b0 && k < max_cycles);
      check("busy_clears", 32'(busy), 32'd0);
   endtask

   initial begin
      #900_000;
      $display("FAIL watchdog: got time %0t, expected completion before it", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int base, lat, guard;
      logic [31:0] words [5];

      // Single write: fsin timing, serialisation and busy fall.
      do_reset();
      base = frames;
      push_word(32'h0001_0832);
      repeat (3) tick();
      drdy_pulse(2);
      lat = 0;
      do begin @(negedge aclk); lat++; end while (adc_fsin !== 1'b0 && lat < 10);
      check("fsin_latency", 32'(lat), 32'd3);
      @(negedge aclk);
      check("fsin_one_cycle", 32'(adc_fsin), 32'd1);
      repeat (30 + GAP_CYCLES) @(negedge aclk);
      check("busy_in_gap", 32'(busy), 32'd1);
      @(negedge aclk);
      check("busy_falls", 32'(busy), 32'd0);
      check("wr_count_one", 32'(wr_count), 32'd1);
      check("frames_single", 32'(frames - base), 32'd1);

      // Five back-to-back pushes into a four-deep FIFO.
      do_reset();
      base = frames;
      for (int i = 0; i < 5; i++) words[i] = $urandom();
      for (int i = 0; i < 4; i++) push_word(words[i]);
      @(negedge aclk);
      check("ready_low_when_full", 32'(s_cmd_tready), 32'd0);
      fork
         push_word(words[4]);
         begin
            repeat (3) tick();
            for (int p = 0; p < 5; p++) begin
               drdy_pulse(2);
               repeat (48) tick();
            end
         end
      join
      wait_idle(200);
      check("frames_full_fifo", 32'(frames - base), 32'd5);
      check("wr_count_five", 32'(wr_count), 32'd5);

      // A frame-end during SHIFT is ignored.
      do_reset();
      base = frames;
      push_word(32'hA5A5_0001);
      push_word(32'h5A5A_0002);
      repeat (3) tick();
      drdy_pulse(2);
      repeat (8) tick();
      drdy_pulse(2);
      repeat (40) tick();
      @(negedge aclk);
      check("second_pulse_ignored", 32'(frames - base), 32'd1);
      check("busy_word_waiting", 32'(busy), 32'd1);
      drdy_pulse(2);
      wait_idle(200);
      check("third_pulse_sends", 32'(frames - base), 32'd2);

      // DRDY timeout, clear, and set-wins-over-clear.
      do_reset();
      base = frames;
      push_word(32'h1234_5678);
      lat = 0;
      do begin @(negedge aclk); lat++; end while (timeout !== 1'b1 && lat < 1200);
      check("timeout_set", 32'(timeout), 32'd1);
      check("timeout_latency_ok", 32'(lat >= 1020 && lat <= 1030), 32'd1);
      check("timeout_busy", 32'(busy), 32'd0);
      check("timeout_wr_count", 32'(wr_count), 32'd0);
      check("timeout_no_frame", 32'(frames - base), 32'd0);
      tick();
      timeout_clr = 1'b1;
      tick();
      timeout_clr = 1'b0;
      @(negedge aclk);
      check("timeout_cleared", 32'(timeout), 32'd0);
      push_word(32'h8765_4321);
      timeout_clr = 1'b1;
      lat = 0;
      do begin @(negedge aclk); lat++; end while (timeout !== 1'b1 && lat < 1200);
      check("timeout_set_wins", 32'(timeout), 32'd1);
      tick();
      timeout_clr = 1'b0;
      @(negedge aclk);
      check("timeout_clr_after", 32'(timeout), 32'd0);

      // Reset during SHIFT cycle 15 aborts the frame and drops the word.
      do_reset();
      push_word(32'hFFFF_FFFF);
      repeat (3) tick();
      drdy_pulse(2);
      lat = 0;
      do begin @(negedge aclk); lat++; end while (adc_fsin !== 1'b0 && lat < 10);
      check("abort_frame_started", 32'(adc_fsin), 32'd0);
      repeat (15) @(posedge aclk);
      #1; rst = 1'b1;
      @(negedge aclk);
      @(negedge aclk);
      check("abort_fsin", 32'(adc_fsin), 32'd1);
      check("abort_sdi", 32'(adc_sdi), 32'd0);
      check("abort_wr_count", 32'(wr_count), 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      @(posedge aclk); #1; rst = 1'b0;
      tick();
      base = frames;
      drdy_pulse(2);
      repeat (50) tick();
      @(negedge aclk);
      check("abort_fifo_empty", 32'(frames - base), 32'd0);
      check("abort_idle", 32'(busy), 32'd0);

      // Randomised traffic against the scoreboard.
      do_reset();
      base = frames;
      push_done = 1'b0;
      guard = 0;
      fork
         begin
            for (int i = 0; i < 20; i++) begin
               repeat ($urandom_range(0, 30)) tick();
               push_word($urandom());
            end
            push_done = 1'b1;
         end
         begin
            while (!(push_done && busy === 1'b0) && guard < 200) begin
               repeat ($urandom_range(3, 50)) tick();
               drdy_pulse(int'($urandom_range(1, 3)));
               guard++;
            end
         end
      join
      wait_idle(200);
      check("rand_all_sent", 32'(exp_q.size()), 32'd0);
      check("rand_frames", 32'(frames - base), 32'd20);
      check("rand_wr_count", 32'(wr_count), 32'd20);

      // wr_count wraps from 0xFFFF.
      do_reset();
      force dut.wr_count_q = 16'hFFFF;
      tick();
      release dut.wr_count_q;
      exp_wr = 16'hFFFF;
      push_word(32'h0003_00FF);
      repeat (3) tick();
      drdy_pulse(2);
      wait_idle(200);
      check("wr_count_wrap", 32'(wr_count), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/ad7763_cfg_sequencer.md
AD7763_CFG_SEQUENCER -- requirements
Module: ad7763_cfg_sequencer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4: command FIFO depth in 32-bit words (power of two, >=2).
REQ-002 SHALL have parameter GAP_CYCLES, default 8: idle aclk cycles after each write, with adc_fsin high and adc_sdi 0.
REQ-003 SHALL have parameter DRDY_TIMEOUT, default 1024: aclk cycles to wait for a DRDY frame end before abandoning a word.
REQ-004 SHALL have one clock; reset is synchronous and active-high.
REQ-005 aclk  in  1  sole clock, SCO-synchronous (40 MHz nominal); all logic on rising edge.
REQ-006 rst  in  1  synchronous reset, active-high.
REQ-007 s_cmd_tdata  in  32  [31:16] AD7763 register address, [15:0] register data.
REQ-008 s_cmd_tvalid  in  1  command word valid.
REQ-009 s_cmd_tready  out  1  FIFO can accept a word.
REQ-010 adc_dreadyn  in  1  ADC DRDY, active-low.
REQ-011 adc_fsin  out  1  ADC frame sync in, active-low.
REQ-012 adc_sdi  out  1  ADC serial data in.
REQ-013 busy  out  1  high while FIFO non-empty or FSM not in IDLE.
REQ-014 wr_count  out  16  completed-write counter.
REQ-015 timeout  out  1  sticky DRDY-timeout flag.
REQ-016 timeout_clr  in  1  clears timeout; single-cycle pulse.

Function
REQ-017 SHALL accept a word on an edge where s_cmd_tvalid and s_cmd_tready are both high; s_cmd_tready = FIFO not full.
REQ-018 SHALL handle a push and a pop in the same cycle when the FIFO is non-full, with occupancy unchanged.
REQ-019 SHALL register adc_dreadyn once; the frame-end event is the registered value low then high on consecutive edges.
REQ-020 SHALL implement FSM states IDLE, WAIT_DRDY, SHIFT, GAP.
REQ-021 IDLE -> WAIT_DRDY when the FIFO is non-empty; the timeout counter clears on entry.
REQ-022 WAIT_DRDY: on frame-end event, pop the FIFO head into a 32-bit shift register and go to SHIFT; the counter increments each cycle otherwise.
REQ-023 WAIT_DRDY: counter reaching DRDY_TIMEOUT without an event -> pop and discard head, set timeout, go to IDLE; wr_count is not incremented.
REQ-024 SHIFT cycle 0 (the edge after the event edge): adc_fsin=0, adc_sdi=bit31.
REQ-025 SHIFT cycles 1..31: adc_fsin=1, adc_sdi=bit(31-n), MSB first, one bit per aclk.
REQ-026 After cycle 31: wr_count += 1 (wraps 0xFFFF -> 0x0000), go to GAP.
REQ-027 GAP: GAP_CYCLES cycles with adc_fsin=1, adc_sdi=0, then IDLE; a new event during GAP is ignored.
REQ-028 adc_fsin and adc_sdi SHALL be driven directly from flip-flops.
REQ-029 A frame-end event SHALL be ignored in IDLE, SHIFT and GAP.
REQ-030 timeout_clr in the same cycle as a new timeout SHALL leave timeout set (set wins).
REQ-031 FIFO words SHALL be transmitted in arrival order with none lost while s_cmd_tready is high.

Reset
REQ-032 On rst: adc_fsin=1, adc_sdi=0, s_cmd_tready=0 during rst then 1 on the first edge after rst falls, busy=0, wr_count=0, timeout=0, FSM=IDLE, FIFO empty, counters 0.
REQ-033 rst asserted mid-SHIFT SHALL abort the frame on that edge (adc_fsin=1, adc_sdi=0), with no wr_count increment and the word lost.

Verification
REQ-034 Push 0x0001_0832, DRDY pulse low 2 cycles -> adc_fsin low exactly 1 cycle, the edge after dreadyn returns high; adc_sdi serialises 0x00010832 MSB first; wr_count=1; busy falls GAP_CYCLES+1 cycles after bit0.
REQ-035 Push 5 words back-to-back with no DRDY -> 4 accepted, s_cmd_tready low after the 4th; after DRDY pulses all 4 are sent in order; the 5th is accepted once the first pops.
REQ-036 Push 1 word, hold adc_dreadyn high -> after 1024 cycles timeout=1, busy=0, wr_count=0, adc_fsin never low; timeout_clr pulse -> timeout=0.
REQ-037 Two DRDY pulses 10 cycles apart with 2 words queued -> second pulse falls in SHIFT and is ignored; the second word is sent on the third pulse.
REQ-038 rst at SHIFT cycle 15 -> next edge adc_fsin=1, adc_sdi=0, wr_count=0, FIFO empty.
REQ-039 wr_count preloaded to 0xFFFF by 65535 writes (or force) plus one more write -> 0x0000.
